// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module : sdram_pkg
// Brief  : Shared widths, request record and request-queue FSM states.
// Rev    : 1.0
// ============================================================================
package sdram_pkg;

  localparam int c_A_ROW_WIDTH = 13;
  localparam int c_A_COL_WIDTH = 10;
  localparam int c_A_WIDTH     = c_A_ROW_WIDTH + c_A_COL_WIDTH;
  localparam int c_BA_WIDTH    = 2;
  localparam int c_D_WIDTH     = 16;

  typedef struct packed {
    logic                  rw;
    logic [c_BA_WIDTH-1:0] ba;
    logic [c_A_WIDTH-1:0]  addr;
    logic [c_D_WIDTH-1:0]  data;
  } sdram_req_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } sdram_req_state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_req_fifo.sv
`default_nettype none
// ============================================================================
// Module : sdram_req_fifo
// Brief  : Synchronous FIFO of sdram_req_t; a push is refused while full.
// Rev    : 1.0
// ============================================================================
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  sdram_req_t             i_data,
  output sdram_req_t             o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int c_AW = $clog2(DEPTH);

  sdram_req_t        r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == (c_AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  // Full refuses a push even when a pop frees a slot in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/sdram_req_queue.sv
`default_nettype none
// ============================================================================
// Module : sdram_req_queue
// Brief  : Buffers user requests and issues them one at a time to the SDRAM
//          controller, returning read data in order. Optional macro:
//          SDRAM_REQ_TIMEOUT_EN enables the WAIT_ACK timeout and o_err.
// Rev    : 1.0
// ============================================================================
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int A_ROW_WIDTH = c_A_ROW_WIDTH,
  parameter int A_COL_WIDTH = c_A_COL_WIDTH,
  parameter int BA_WIDTH    = c_BA_WIDTH,
  parameter int D_WIDTH     = c_D_WIDTH,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic                           i_req_rw,
  input  logic [A_ROW_WIDTH+A_COL_WIDTH-1:0] i_req_addr,
  input  logic [BA_WIDTH-1:0]            i_req_ba,
  input  logic [D_WIDTH-1:0]             i_req_data,
  output logic                           o_rsp_valid,
  output logic [D_WIDTH-1:0]             o_rsp_data,
  output logic                           o_initial,
  output logic                           o_rw,
  output logic [A_ROW_WIDTH+A_COL_WIDTH-1:0] o_addr,
  output logic [BA_WIDTH-1:0]            o_ba,
  output logic [D_WIDTH-1:0]             o_wdata,
  input  logic                           i_busy,
  input  logic [D_WIDTH-1:0]             i_rdata,
  output logic [$clog2(DEPTH):0]         o_level,
  output logic                           o_err
);

  localparam int c_LW = $clog2(DEPTH) + 1;

  sdram_req_state_t r_state;
  sdram_req_state_t w_next;
  sdram_req_t       w_req_in;
  sdram_req_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_done;
  logic             w_timeout;
  logic [c_LW-1:0]  w_level;

  logic                               r_rw;
  logic [A_ROW_WIDTH+A_COL_WIDTH-1:0] r_addr;
  logic [BA_WIDTH-1:0]                r_ba;
  logic [D_WIDTH-1:0]                 r_wdata;
  logic                               r_rsp_valid;
  logic [D_WIDTH-1:0]                 r_rsp_data;

  assign w_req_in = '{rw: i_req_rw, ba: i_req_ba, addr: i_req_addr, data: i_req_data};

  sdram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_req_valid),
    .i_pop   (w_pop),
    .i_data  (w_req_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign o_level     = w_level;
  assign o_req_ready = (w_level != c_LW'(DEPTH));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (!w_empty && !i_busy) w_next = S_ISSUE;
      S_ISSUE:     w_next = S_WAIT_ACK;
      S_WAIT_ACK:  if (i_busy) w_next = S_WAIT_DONE;
                   else if (w_timeout) w_next = S_IDLE;
      S_WAIT_DONE: if (!i_busy) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_initial = (r_state == S_ISSUE);
    w_pop     = (r_state == S_IDLE) && !w_empty && !i_busy;
    w_done    = (r_state == S_WAIT_DONE) && !i_busy;
  end

  // Request fields are held from the pop until the next pop.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_ba        <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      if (w_pop) begin
        r_rw    <= w_head.rw;
        r_addr  <= w_head.addr;
        r_ba    <= w_head.ba;
        r_wdata <= w_head.data;
      end
      r_rsp_valid <= w_done && !r_rw;
      if (w_done && !r_rw) r_rsp_data <= i_rdata;
    end
  end

  assign o_rw        = r_rw;
  assign o_addr      = r_addr;
  assign o_ba        = r_ba;
  assign o_wdata     = r_wdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;

`ifdef SDRAM_REQ_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT + 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_err;

  assign w_timeout = (r_state == S_WAIT_ACK) && !i_busy &&
                     (r_to_cnt == c_TO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state != S_WAIT_ACK) r_to_cnt <= '0;
      else                       r_to_cnt <= r_to_cnt + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_sdram_req_queue
// Brief  : Scoreboard bench for sdram_req_queue with a busy/rdata controller model.
// Rev    : 1.0
// ============================================================================
module tb_sdram_req_queue;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [22:0] req_addr = '0;
  logic [1:0]  req_ba = '0;
  logic [15:0] req_data = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        initial_s;
  logic        rw;
  logic [22:0] addr;
  logic [1:0]  ba;
  logic [15:0] wdata;
  logic        busy;
  logic [15:0] rdata = '0;
  logic [2:0]  level;
  logic        err;

  logic m_en = 1'b1, m_busy = 1'b0, f_busy = 1'b0, prev_init = 1'b0;
  assign busy = m_busy | f_busy;

  int checks = 0;
  int failures = 0;

  sdram_req_t  exp_iss[$];
  logic [15:0] exp_rsp[$];
  logic [15:0] rdata_q[$];

  always #5 clk = ~clk;

  sdram_req_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_rw(req_rw), .i_req_addr(req_addr), .i_req_ba(req_ba), .i_req_data(req_data),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_initial(initial_s), .o_rw(rw), .o_addr(addr), .o_ba(ba), .o_wdata(wdata),
    .i_busy(busy), .i_rdata(rdata), .o_level(level), .o_err(err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Scoreboard monitor: compare every issue strobe and every response.
  always @(negedge clk) begin
    sdram_req_t e;
    logic [15:0] d;
    if (initial_s) begin
      check("initial_single_cycle", {31'b0, prev_init}, 32'd0);
      if (exp_iss.size() == 0) begin
        check("unexpected_issue", 32'd1, 32'd0);
      end else begin
        e = exp_iss.pop_front();
        check("issue_rw", {31'b0, rw}, {31'b0, e.rw});
        check("issue_addr", {9'b0, addr}, {9'b0, e.addr});
        check("issue_ba", {30'b0, ba}, {30'b0, e.ba});
        if (e.rw) check("issue_wdata", {16'b0, wdata}, {16'b0, e.data});
      end
    end
    prev_init = initial_s;
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        d = exp_rsp.pop_front();
        check("rsp_data", {16'b0, rsp_data}, {16'b0, d});
      end
    end
  end

  // Controller model: busy high for 3 cycles after the strobe, read data as busy falls.
  initial begin
    forever begin
      @(negedge clk);
      if (initial_s && m_en) begin
        m_busy = 1'b1;
        repeat (3) @(negedge clk);
        if (!rw && rdata_q.size() > 0) rdata = rdata_q.pop_front();
        m_busy = 1'b0;
      end
    end
  end

  task automatic expect_req(input logic r, input logic [22:0] a, input logic [1:0] b,
                            input logic [15:0] d, input logic want_rsp);
    sdram_req_t e;
    e.rw = r; e.addr = a; e.ba = b; e.data = d;
    exp_iss.push_back(e);
    if (!r && want_rsp) begin
      exp_rsp.push_back(d);
      rdata_q.push_back(d);
    end
  endtask

  task automatic push(input logic r, input logic [22:0] a, input logic [1:0] b, input logic [15:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_rw = r; req_addr = a; req_ba = b; req_data = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_iss.size() != 0 || exp_rsp.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_initial();
    int n = 0;
    @(negedge clk);
    while (!initial_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("initial_wait_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    check("reset_level", {29'b0, level}, 32'd0);
    check("reset_strobes", {30'b0, initial_s, rsp_valid}, 32'd0);
    check("reset_fields", {rw, ba, wdata}, 32'd0);
    check("reset_addr_err", {8'b0, addr, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, no response
    expect_req(1'b1, 23'h000123, 2'd1, 16'hBEEF, 1'b0);
    push(1'b1, 23'h000123, 2'd1, 16'hBEEF);
    wait_drain();

    // Single read with best-case strobe timing
    expect_req(1'b0, 23'h000456, 2'd2, 16'h5A5A, 1'b1);
    push(1'b0, 23'h000456, 2'd2, 16'h0000);
    @(negedge clk);
    check("n1_level", {29'b0, level}, 32'd1);
    check("n1_no_initial", {31'b0, initial_s}, 32'd0);
    @(negedge clk);
    check("n2_initial", {31'b0, initial_s}, 32'd1);
    wait_drain();
    check("rsp_data_hold", {16'b0, rsp_data}, 32'h5A5A);

    // Full FIFO while busy
    f_busy = 1'b1;
    expect_req(1'b1, 23'h000010, 2'd0, 16'h1001, 1'b0);
    expect_req(1'b0, 23'h000020, 2'd1, 16'h1111, 1'b1);
    expect_req(1'b1, 23'h000030, 2'd2, 16'h3003, 1'b0);
    expect_req(1'b0, 23'h000040, 2'd3, 16'h2222, 1'b1);
    push(1'b1, 23'h000010, 2'd0, 16'h1001);
    push(1'b0, 23'h000020, 2'd1, 16'h0000);
    push(1'b1, 23'h000030, 2'd2, 16'h3003);
    push(1'b0, 23'h000040, 2'd3, 16'h0000);
    @(negedge clk);
    check("full_level", {29'b0, level}, 32'd4);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 23'h000050; req_ba = 2'd0; req_data = 16'hDEAD;
    check("full_not_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("full_level_after_5th", {29'b0, level}, 32'd4);
    f_busy = 1'b0;
    wait_drain();
    check("drained_level", {29'b0, level}, 32'd0);

    // Reset while in WAIT_DONE
    m_en = 1'b0;
    expect_req(1'b0, 23'h000077, 2'd1, 16'h0000, 1'b0);
    push(1'b0, 23'h000077, 2'd1, 16'h0000);
    wait_initial();
    f_busy = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    f_busy = 1'b0;
    rdata = 16'hDEAD;
    @(negedge clk);
    check("midrst_level", {29'b0, level}, 32'd0);
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_rsp_data", {16'b0, rsp_data}, 32'd0);
    check("midrst_fields", {8'b0, addr, rw}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    m_en = 1'b1;
    expect_req(1'b1, 23'h000099, 2'd3, 16'hCAFE, 1'b0);
    push(1'b1, 23'h000099, 2'd3, 16'hCAFE);
    @(negedge clk);
    @(negedge clk);
    check("postrst_n2_initial", {31'b0, initial_s}, 32'd1);
    wait_drain();

`ifdef SDRAM_REQ_TIMEOUT_EN
    // Controller never raises busy
    m_en = 1'b0;
    expect_req(1'b1, 23'h000ABC, 2'd2, 16'h7777, 1'b0);
    push(1'b1, 23'h000ABC, 2'd2, 16'h7777);
    wait_initial();
    repeat (8) @(negedge clk);
    check("err_before_timeout", {31'b0, err}, 32'd0);
    @(negedge clk);
    check("err_after_timeout", {31'b0, err}, 32'd1);
    m_en = 1'b1;
    expect_req(1'b0, 23'h000DEF, 2'd1, 16'hC0DE, 1'b1);
    push(1'b0, 23'h000DEF, 2'd1, 16'h0000);
    wait_drain();
    check("err_sticky", {31'b0, err}, 32'd1);
`else
    check("err_tied_low", {31'b0, err}, 32'd0);
`endif

    check("iss_queue_empty", exp_iss.size(), 32'd0);
    check("rsp_queue_empty", exp_rsp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_req_queue.md
# sdram_req_queue

Request-side front end for the SDRAM controller. It buffers single-word read/write requests from user logic in a small FIFO and issues them to the controller one at a time, only while the controller is not busy. It returns read data to the requester in issue order. It sits directly upstream of the controller and drives its `i_initial`, `i_rw`, `i_addr`, `i_ba` and `i_data` inputs; it consumes the controller's `busy` and `o_data` outputs.

## Interface
- `A_ROW_WIDTH`, 13: row address bits.
- `A_COL_WIDTH`, 10: column address bits.
- `BA_WIDTH`, 2: bank address bits.
- `D_WIDTH`, 16: data word width.
- `DEPTH`, 4: request FIFO entries; must be a power of two, ≥2.
- `TIMEOUT`, 1023: maximum cycles to wait for the controller to accept a request (used only with `SDRAM_REQ_TIMEOUT_EN`).
- `i_clk` in 1: system clock, 100 MHz.
- `i_rst` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `i_req_valid` in 1: user request valid.
- `o_req_ready` out 1: the FIFO can accept a request.
- `i_req_rw` in 1: 1 = write, 0 = read.
- `i_req_addr` in A_ROW_WIDTH+A_COL_WIDTH: row (MSBs) and column address.
- `i_req_ba` in BA_WIDTH: bank.
- `i_req_data` in D_WIDTH: write data; ignored for reads.
- `o_rsp_valid` out 1: one-cycle pulse, read data valid.
- `o_rsp_data` out D_WIDTH: read data.
- `o_initial` out 1: one-cycle request strobe to the controller.
- `o_rw`, `o_addr`, `o_ba`, `o_wdata` out (widths as the request fields): request fields to the controller.
- `i_busy` in 1: controller busy.
- `i_rdata` in D_WIDTH: controller read data.
- `o_level` out $clog2(DEPTH)+1: FIFO occupancy.
- `o_err` out 1: sticky timeout flag.

## Operation
- **Enqueue:** a request enters the FIFO when `i_req_valid && o_req_ready`.
  - `o_req_ready = (o_level != DEPTH)`, combinational from the count.
  - When the FIFO is full, a push is refused even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave `o_level` unchanged.
- **FSM states:** IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE: if the FIFO is not empty and `!i_busy`, pop the head, register the fields onto `o_rw/o_addr/o_ba/o_wdata`, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `o_initial = 1` for exactly this cycle; go to WAIT_ACK.
  - WAIT_ACK: stay until `i_busy == 1`, then go to WAIT_DONE.
  - WAIT_DONE: stay until `i_busy == 0`.
    - In that cycle, a read captures `i_rdata` into `o_rsp_data`.
    - Go to IDLE.
- **Response:** `o_rsp_valid` pulses in the cycle after the WAIT_DONE exit, for reads only.
  - `o_rsp_data` holds its value until the next read completes.
  - There is no response backpressure.
- **Request fields:** `o_rw/o_addr/o_ba/o_wdata` stay stable from ISSUE until the next pop.
- **Pointers:** FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally; `o_level` is a separate counter.
- **Reset:** asserting reset mid-operation aborts any in-flight request, empties the FIFO and returns to IDLE. No response is produced for the aborted request.
- **Reset values:** `o_req_ready` = 1; all other outputs = 0; state = IDLE.

## Timing
- A push at cycle N makes the entry poppable at N+1.
- Best case, `o_initial` rises at N+2.
- Read response latency: `o_rsp_valid` rises one cycle after the first cycle in which `i_busy` is observed low following a high.
- Back-to-back requests: the next pop can occur in IDLE the cycle after WAIT_DONE exits, provided `i_busy` is low.
- A refresh-induced `i_busy` while the block is in IDLE only delays the issue; the FIFO continues to accept requests.

## Configuration
- `SDRAM_REQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT_ACK.
  - If `i_busy` stays low for TIMEOUT cycles, `o_err` is set (sticky until reset) and the FSM returns to IDLE.
  - The dropped request produces no response.
- Undefined: WAIT_ACK waits indefinitely and `o_err` is tied to 0.

## Structure
- Package `sdram_pkg` holds the width constants, the `sdram_req_t` struct (rw, ba, addr, data) and the FSM state enum. The controller shares this package.
- One sub-module: `sdram_req_fifo`, a synchronous FIFO of `sdram_req_t` with push, pop, full, empty and level.
- The FSM and response logic live in the top level.

## Test plan
1. **Reset:** `i_rst` low → all outputs 0 except `o_req_ready` = 1; `o_level` = 0.
2. **Single write:** push write addr=0x000123, ba=1, data=0xBEEF; model busy high 3 cycles after `o_initial`.
   - Expect `o_initial` one cycle, with `o_addr`=0x000123, `o_ba`=1, `o_wdata`=0xBEEF.
   - Expect no `o_rsp_valid`.
3. **Read:** push read; the model drives `i_rdata`=0x5A5A as busy falls → `o_rsp_valid` pulses once with `o_rsp_data`=0x5A5A.
4. **Full FIFO:** hold `i_busy` high and push 5 requests.
   - Expect only 4 accepted: `o_level`=4 and `o_req_ready`=0 on the 5th.
   - Release busy → 4 issues in order, with reads returned in order.
5. **Reset mid-flight:** assert `i_rst` in WAIT_DONE → no response, FSM in IDLE, FIFO empty.
6. **Timeout** (with `SDRAM_REQ_TIMEOUT_EN`, TIMEOUT=8): the model never raises busy.
   - Expect `o_err`=1 after 8 WAIT_ACK cycles, FSM back in IDLE.
   - The next request is still issued.
